// File: rtl/switch_debouncer.sv
// Switch/button conditioner: per-bit synchroniser, stability-counter debounce
// filter and a registered one-cycle "changed" strobe.
// Optional feature macro: DEBOUNCE_EDGE_EN adds per-bit rise/fall strobes.
module switch_debouncer #(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int             CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // Synchroniser chain; stage 0 samples the raw pin, the last stage is the
    // clean in-domain copy used by the filter.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] accept;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw levels through the synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    // Per-bit filter decision: restart on agreement, count on disagreement,
    // accept the new level once the count has reached its last value.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s[i] != sw_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i]   = 1'b1;
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Stability counters; clearing on accept means they never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Debounced levels flip on accept; the strobe marks the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_out  <= '0;
            changed <= 1'b0;
        end else begin
            sw_out  <= sw_out ^ accept;
            changed <= |accept;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    // Direction strobes, aligned with changed; the accepted level is s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (WIDTH=2, CNT_MAX=4, SYNC_STAGES=2): directed
// scenarios with literal expectations plus randomized levels checked every
// cycle against a window-based behavioural model.
module tb_switch_debouncer;

    localparam int WIDTH       = 2;
    localparam int CNT_MAX     = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             changed;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 0;

    switch_debouncer #(
        .WIDTH      (WIDTH),
        .CNT_MAX    (CNT_MAX),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .changed(changed)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .rise   (rise_w),
        .fall   (fall_w)
`endif
    );

`ifndef DEBOUNCE_EDGE_EN
    assign rise_w = '0;
    assign fall_w = '0;
`endif

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Behavioural model: a bit flips at an edge when the synchronised input
    // (raw input delayed by SYNC_STAGES edges) has disagreed with the output on
    // each of the last CNT_MAX edges.
    logic [WIDTH-1:0] in_q   [$];
    logic [WIDTH-1:0] s_hist [$];
    logic [3*WIDTH:0] exp_q  [$];
    logic [WIDTH-1:0] m_out, m_rise, m_fall, s_now;
    logic             m_ch;
    bit               flip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0;
            in_q.delete();
            for (int k = 0; k < SYNC_STAGES; k++) in_q.push_back('0);
            s_hist.delete();
            exp_q.delete();
        end else begin
            s_now = (in_q.size() > 0) ? in_q.pop_front() : '0;
            in_q.push_back(sw_in);
            s_hist.push_back(s_now);
            if (s_hist.size() > CNT_MAX) void'(s_hist.pop_front());
            m_ch   = 1'b0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                flip = (s_hist.size() == CNT_MAX);
                foreach (s_hist[k]) if (s_hist[k][i] == m_out[i]) flip = 0;
                if (flip) begin
                    m_out[i] = ~m_out[i];
                    m_ch     = 1'b1;
                    if (m_out[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                end
            end
            exp_q.push_back({m_rise, m_fall, m_ch, m_out});
        end
    end

    // Scoreboard compare, away from the active edge.
    logic [3*WIDTH:0] e;
    always @(negedge clk) begin
        if (check_en) begin
            if (!rst_n) begin
                check("rst_sw_out", 8'(sw_out), 8'h0);
                check("rst_changed", 8'(changed), 8'h0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sw_out", 8'(sw_out), 8'(e[WIDTH-1:0]));
                check("changed", 8'(changed), 8'(e[WIDTH]));
`ifdef DEBOUNCE_EDGE_EN
                check("fall", 8'(fall_w), 8'(e[2*WIDTH:WIDTH+1]));
                check("rise", 8'(rise_w), 8'(e[3*WIDTH:2*WIDTH+1]));
`endif
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic [WIDTH-1:0] v);
        @(negedge clk);
        sw_in = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        hold(cycles);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst_n = 1'b1;
        sw_in = 2'b11;
        // Asynchronous reset asserted mid-cycle.
        edges(3);
        #1 rst_n = 1'b0;
        #1;
        check("t1_async_sw_out", 8'(sw_out), 8'h0);
        check("t1_async_changed", 8'(changed), 8'h0);
        check_en = 1;
        sw_in = 2'b00;
        hold(3);
        #2 rst_n = 1'b1;
        hold(4);

        // Glitch on bit 0 shorter than the filter window.
        drive(2'b01);
        hold(2);
        drive(2'b00);
        for (int k = 0; k < 10; k++) begin
            edges(1);
            check("t4_glitch_out", 8'(sw_out), 8'h0);
            check("t4_glitch_chg", 8'(changed), 8'h0);
        end

        // Clean edge on bit 0.
        drive(2'b01);
        edges(5);
        check("t2_pre_out", 8'(sw_out), 8'h0);
        edges(1);
        check("t2_out", 8'(sw_out), 8'h1);
        check("t2_changed", 8'(changed), 8'h1);
`ifdef DEBOUNCE_EDGE_EN
        check("t2_rise", 8'(rise_w), 8'h1);
        check("t2_fall", 8'(fall_w), 8'h0);
`endif
        edges(1);
        check("t2_changed_off", 8'(changed), 8'h0);

        // Bounce on bit 1, two cycles per level, then settle high.
        drive(2'b11);
        hold(1);
        drive(2'b01);
        hold(1);
        drive(2'b11);
        edges(5);
        check("t3_pre_out", 8'(sw_out), 8'h1);
        edges(1);
        check("t3_out", 8'(sw_out), 8'h3);
        check("t3_changed", 8'(changed), 8'h1);

        // Simultaneous edge on both bits.
        drive(2'b00);
        hold(12);
        drive(2'b11);
        edges(5);
        check("t5_pre_out", 8'(sw_out), 8'h0);
        edges(1);
        check("t5_out", 8'(sw_out), 8'h3);
        check("t5_changed", 8'(changed), 8'h1);
`ifdef DEBOUNCE_EDGE_EN
        check("t5_rise", 8'(rise_w), 8'h3);
        check("t5_fall", 8'(fall_w), 8'h0);
`endif
        edges(1);
        check("t5_changed_off", 8'(changed), 8'h0);

        // Reset in the middle of a count, then accept after release.
        drive(2'b00);
        hold(12);
        drive(2'b10);
        edges(3);
        do_reset(2);
        edges(5);
        check("t6_pre_out", 8'(sw_out), 8'h0);
        edges(1);
        check("t6_out", 8'(sw_out), 8'h2);
        check("t6_changed", 8'(changed), 8'h1);
        drive(2'b00);
        edges(6);
        check("t6_fall_out", 8'(sw_out), 8'h0);
`ifdef DEBOUNCE_EDGE_EN
        check("t6_fall", 8'(fall_w), 8'h2);
        check("t6_rise", 8'(rise_w), 8'h0);
`endif

        // Randomized levels with varied hold times and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            drive(2'($urandom_range(0, 3)));
            hold($urandom_range(0, 7));
        end
        hold(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
